lamp_sequence_player: RTL and testbench

// - Stimulus source for the 3-lamp 1-2-3 sequence detector: plays a programmable pattern of lamp

---
 rtl/lamp_seq_pkg.sv | 22 ++
 rtl/lamp_seq_shadow.sv | 39 +++
 rtl/lamp_sequence_player.sv | 158 +++++++++++++++
 tb/tb_lamp_sequence_player.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/lamp_seq_pkg.sv
// Shared types and helpers for the lamp sequence player and its shadow 1-2-3 tracker.
package lamp_seq_pkg;

  typedef logic [1:0] lamp_code_t;

  typedef enum logic [1:0] {IDLE, SHOW, DONE} play_state_t;

  typedef enum logic [1:0] {S0, S1, S2, HIT} shadow_state_t;

  // Code 0 means all lamps off; codes 1..3 light lamp 1..3 (bit0 = lamp 1).
  function automatic logic [2:0] code_to_onehot(lamp_code_t code);
    logic [2:0] onehot;
    case (code)
      2'd1:    onehot = 3'b001;
      2'd2:    onehot = 3'b010;
      2'd3:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/lamp_seq_shadow.sv
// Golden 1-2-3 run tracker, advanced once per played step; hit is high for the step completing a run.
module lamp_seq_shadow
  import lamp_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       step_en,
  input  lamp_code_t code,
  output logic       hit
);

  shadow_state_t state_reg;
  shadow_state_t state_next;
  logic          hit_reg;

  always_comb begin
    state_next = S0;
    if (code == 2'd1)
      state_next = S1;
    else if (state_reg == S1 && code == 2'd2)
      state_next = S2;
    else if (state_reg == S2 && code == 2'd3)
      state_next = HIT;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state_reg <= S0;
      hit_reg   <= 1'b0;
    end else if (step_en) begin
      state_reg <= state_next;
      hit_reg   <= (state_next == HIT);
    end
  end

  assign hit = hit_reg;

endmodule

// File: rtl/lamp_sequence_player.sv
// Plays a programmable pattern of lamp codes onto a one-hot lamp bus, with a golden
// expect_alarm flag marking each step that completes a 1-2-3 run.
module lamp_sequence_player
  import lamp_seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [1:0]        wr_data,
  input  logic [AW:0]       len,
  input  logic [HOLD_W-1:0] hold,
  input  logic              loop,
  input  logic              start,
  input  logic              stop,
  output logic [2:0]        lamps,
  output logic              step_valid,
  output logic              expect_alarm,
  output logic              busy,
  output logic              done
);

  play_state_t       state_reg;
  logic [AW-1:0]     idx_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [AW:0]       len_reg;
  logic              loop_reg;
  logic              stop_seen_reg;
  logic [2:0]        lamps_reg;
  logic              step_valid_reg;
  logic              busy_reg;
  logic              done_reg;

  lamp_code_t        mem_reg [DEPTH];
  logic [DEPTH-1:0]  wr_sel;

  logic              wr_ok;
  logic              start_ok;
  logic              step_end;
  logic              last_step;
  logic              go_done;
  logic              advance;
  logic              step_en;
  logic              shadow_clr;
  logic [AW-1:0]     idx_adv;
  logic [AW-1:0]     fetch_idx;
  lamp_code_t        fetch_code;
  logic [AW:0]       len_eff;

  assign wr_ok = wr_en && (state_reg != SHOW);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_ok && (wr_addr == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_sel[i]) mem_reg[i] <= wr_data;
    end
  end

  assign len_eff   = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
  assign start_ok  = (state_reg == IDLE) && start && (len != '0);
  assign step_end  = (state_reg == SHOW) && (hold_cnt_reg == '0);
  assign last_step = ({1'b0, idx_reg} == len_reg - (AW+1)'(1));
  assign go_done   = step_end && (stop_seen_reg || stop || (last_step && !loop_reg));
  assign advance   = step_end && !go_done;
  assign idx_adv   = last_step ? '0 : idx_reg + AW'(1);
  assign fetch_idx = start_ok ? '0 : idx_adv;
  assign step_en   = start_ok || advance;
  assign shadow_clr = go_done || (state_reg == DONE);

  // A write landing in the same cycle as start must be visible in the first fetched step.
  always_comb begin
    fetch_code = mem_reg[fetch_idx];
    if (wr_ok && (wr_addr == fetch_idx))
      fetch_code = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      hold_cnt_reg   <= '0;
      hold_reg       <= '0;
      len_reg        <= '0;
      loop_reg       <= 1'b0;
      stop_seen_reg  <= 1'b0;
      lamps_reg      <= 3'b000;
      step_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      step_valid_reg <= step_en;
      done_reg       <= 1'b0;
      case (state_reg)
        IDLE: begin
          stop_seen_reg <= 1'b0;
          if (start_ok) begin
            state_reg    <= SHOW;
            len_reg      <= len_eff;
            hold_reg     <= hold;
            hold_cnt_reg <= hold;
            // A stop arriving alongside start limits playback to a single pass.
            loop_reg     <= loop && !stop;
            idx_reg      <= '0;
            lamps_reg    <= code_to_onehot(fetch_code);
            busy_reg     <= 1'b1;
          end
        end
        SHOW: begin
          stop_seen_reg <= stop_seen_reg || stop;
          if (go_done) begin
            state_reg <= DONE;
            lamps_reg <= 3'b000;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else if (advance) begin
            idx_reg      <= idx_adv;
            hold_cnt_reg <= hold_reg;
            lamps_reg    <= code_to_onehot(fetch_code);
          end else begin
            hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  lamp_seq_shadow u_shadow (
    .clk     (clk),
    .reset   (reset),
    .clr     (shadow_clr),
    .step_en (step_en),
    .code    (fetch_code),
    .hit     (expect_alarm)
  );

  assign lamps      = lamps_reg;
  assign step_valid = step_valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_lamp_sequence_player.sv
// Directed bench for lamp_sequence_player: hand-computed lamp/flag sequences per cycle.
module tb_lamp_sequence_player;

  localparam int DEPTH  = 16;
  localparam int HOLD_W = 8;
  localparam int AW     = 4;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [1:0]        wr_data;
  logic [AW:0]       len;
  logic [HOLD_W-1:0] hold;
  logic              loop;
  logic              start;
  logic              stop;
  logic [2:0]        lamps;
  logic              step_valid;
  logic              expect_alarm;
  logic              busy;
  logic              done;

  int vectors = 0;
  int miscompares = 0;

  lamp_sequence_player #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .len          (len),
    .hold         (hold),
    .loop         (loop),
    .start        (start),
    .stop         (stop),
    .lamps        (lamps),
    .step_valid   (step_valid),
    .expect_alarm (expect_alarm),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] oh(int c);
    logic [2:0] r;
    r = 3'b000;
    if (c == 1) r = 3'b001;
    if (c == 2) r = 3'b010;
    if (c == 3) r = 3'b100;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [2:0] l, input logic sv,
                     input logic ea, input logic b, input logic d);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {lamps, step_valid, expect_alarm, busy, done};
    exp = {l, sv, ea, b, d};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: lamps/sv/ea/busy/done observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = 2'(d);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int p2 [9] = '{1, 2, 2, 1, 3, 2, 1, 2, 3};
  int p4 [3] = '{2, 3, 1};

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    len = '0; hold = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    tick();
    chk("reset", 3'b000, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle", 3'b000, 0, 0, 0, 0);

    // Basic 1,2,3 run
    wr(0, 1); wr(1, 2); wr(2, 3);
    len = 5'd3; hold = 8'd0; loop = 1'b0;
    go();
    chk("t1 s0", 3'b001, 1, 0, 1, 0); tick();
    chk("t1 s1", 3'b010, 1, 0, 1, 0); tick();
    chk("t1 s2", 3'b100, 1, 1, 1, 0); tick();
    chk("t1 done", 3'b000, 0, 0, 0, 1); tick();
    chk("t1 idle", 3'b000, 0, 0, 0, 0);

    // Nine-step pattern with a single completed run at step 8
    for (int k = 0; k < 9; k++) wr(k, p2[k]);
    len = 5'd9;
    go();
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("t2 s%0d", k), oh(p2[k]), 1, (k == 8), 1, 0);
      tick();
    end
    chk("t2 done", 3'b000, 0, 0, 0, 1);
    tick();

    // hold=3 over two steps, with a write attempted while busy
    len = 5'd2; hold = 8'd3;
    go();
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 2'd3;
      end
      chk($sformatf("t3 c%0d", i + 1), (i < 4) ? 3'b001 : 3'b010, (i == 0 || i == 4), 0, 1, 0);
      tick();
      wr_en = 1'b0;
    end
    chk("t3 done", 3'b000, 0, 0, 0, 1);
    tick();

    // Looping 2,3,1: the run spans the wrap; stop during step 6 ends playback
    for (int k = 0; k < 3; k++) wr(k, p4[k]);
    len = 5'd3; hold = 8'd0; loop = 1'b1;
    go();
    for (int k = 1; k <= 7; k++) begin
      if (k == 7) stop = 1'b1;
      chk($sformatf("t4 c%0d", k), oh(p4[(k - 1) % 3]), 1, (k == 5), 1, 0);
      tick();
    end
    stop = 1'b0;
    chk("t4 done", 3'b000, 0, 0, 0, 1);
    tick();

    // Looping with hold=2: stop mid-step, the step still completes
    hold = 8'd2;
    go();
    chk("t5 c1", 3'b010, 1, 0, 1, 0); tick();
    stop = 1'b1;
    chk("t5 c2", 3'b010, 0, 0, 1, 0); tick();
    stop = 1'b0;
    chk("t5 c3", 3'b010, 0, 0, 1, 0); tick();
    chk("t5 done", 3'b000, 0, 0, 0, 1); tick();
    chk("t5 idle", 3'b000, 0, 0, 0, 0);
    loop = 1'b0; hold = 8'd0;

    // len=0: start ignored
    len = 5'd0;
    go();
    chk("t6 c1", 3'b000, 0, 0, 0, 0); tick();
    chk("t6 c2", 3'b000, 0, 0, 0, 0);

    // Reset during step 2: clean next cycle, no done pulse
    len = 5'd3;
    go();
    chk("t7 s0", 3'b010, 1, 0, 1, 0); tick();
    chk("t7 s1", 3'b100, 1, 0, 1, 0); tick();
    chk("t7 s2", 3'b001, 1, 0, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7 rst", 3'b000, 0, 0, 0, 0); tick();
    chk("t7 nodone", 3'b000, 0, 0, 0, 0);

    // start together with a write: the write is played; memory was cleared by reset
    len = 5'd2;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 2'd3;
    go();
    wr_en = 1'b0;
    chk("t8 s0", 3'b100, 1, 0, 1, 0); tick();
    chk("t8 s1", 3'b000, 1, 0, 1, 0); tick();
    chk("t8 done", 3'b000, 0, 0, 0, 1); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
